// File: rtl/word_serializer.sv
// Parallel-to-serial transmitter: takes one WIDTH-bit word over valid/ready and
// shifts it out one bit per cycle on a d/en strobe pair, counting finished words.
module word_serializer #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             ser_en,
  output logic             ser_d,
  output logic             ser_last,
  output logic             busy,
  output logic [CNT_W-1:0] word_count
);

  localparam int BCW = $clog2(WIDTH);
  localparam logic [BCW-1:0] LAST_IDX = BCW'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   shreg_q;
  logic [BCW-1:0]     bitcnt_q;
  logic               ser_en_q;
  logic               ser_d_q;
  logic               ser_last_q;
  logic               busy_q;
  logic [CNT_W-1:0]   word_count_q;

  logic               in_ready_s;
  logic               accept_s;
  logic               finish_s;

  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return LSB_FIRST ? w[0] : w[WIDTH-1];
  endfunction

  // Remove the head bit so the next one to send sits at the head position.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return LSB_FIRST ? (w >> 1) : (w << 1);
  endfunction

  // Ready is decoded so a new word can be taken while the last bit is on the wire.
  always_comb begin
    in_ready_s = 1'b0;
    case (state_q)
      IDLE:    in_ready_s = 1'b1;
      SHIFT:   in_ready_s = (bitcnt_q == LAST_IDX);
      default: in_ready_s = 1'b0;
    endcase
    accept_s = in_valid && in_ready_s;
    finish_s = (state_q == SHIFT) && (bitcnt_q == LAST_IDX);
  end

  // Transmit FSM with registered serial outputs and completed-word counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      bitcnt_q     <= '0;
      ser_en_q     <= 1'b0;
      ser_d_q      <= 1'b0;
      ser_last_q   <= 1'b0;
      busy_q       <= 1'b0;
      word_count_q <= '0;
    end else begin
      if (finish_s) begin
        word_count_q <= word_count_q + CNT_W'(1);
      end
      if (accept_s) begin
        // The head bit goes straight to ser_d; the remainder waits in shreg_q.
        state_q    <= SHIFT;
        shreg_q    <= advance(in_data);
        bitcnt_q   <= '0;
        ser_en_q   <= 1'b1;
        ser_d_q    <= head_bit(in_data);
        ser_last_q <= 1'b0;
        busy_q     <= 1'b1;
      end else if (finish_s) begin
        state_q    <= IDLE;
        shreg_q    <= '0;
        bitcnt_q   <= '0;
        ser_en_q   <= 1'b0;
        ser_d_q    <= 1'b0;
        ser_last_q <= 1'b0;
        busy_q     <= 1'b0;
      end else if (state_q == SHIFT) begin
        shreg_q    <= advance(shreg_q);
        bitcnt_q   <= bitcnt_q + BCW'(1);
        ser_d_q    <= head_bit(shreg_q);
        ser_last_q <= ((bitcnt_q + BCW'(1)) == LAST_IDX);
      end else begin
        state_q <= IDLE;
      end
    end
  end

  assign in_ready   = in_ready_s;
  assign ser_en     = ser_en_q;
  assign ser_d      = ser_d_q;
  assign ser_last   = ser_last_q;
  assign busy       = busy_q;
  assign word_count = word_count_q;

endmodule

// File: doc/word_serializer.md
Name: word_serializer

Overview:
- Transmit-side counterpart to the enabled capture flop (clk/rst/en/d → q) used across the test designs.
- Accepts a parallel word over a valid/ready handshake and emits it one bit per cycle on a d/en strobe pair, which directly drives chains of enabled capture flops.
- Keeps a free-running count of completed words; this gives the design a real counter register for the analysis flow.

Parameters:
- WIDTH, 8, number of bits per word (≥2).
- LSB_FIRST, 1, 1 = bit 0 is sent first; 0 = bit WIDTH-1 is sent first.
- CNT_W, 16, width of the completed-word counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data is offered.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  WIDTH  parallel word.
- ser_en  output  1  ser_d is valid this cycle; drives the en input of a capture flop.
- ser_d  output  1  serial data bit.
- ser_last  output  1  current ser_d is the final bit of the word.
- busy  output  1  a word is being shifted.
- word_count  output  CNT_W  number of words fully transmitted, modulo 2^CNT_W.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, in_ready=1, ser_en=0, ser_d=0, ser_last=0, busy=0, word_count=0. The shift register and bit counter are cleared.
- All outputs are registered, except in_ready, which is decoded from the current state and bit counter.
- States: IDLE, SHIFT.
- IDLE:
  - in_ready=1.
  - If in_valid: load in_data into the shift register, clear the bit counter, go to SHIFT.
- SHIFT:
  - Each cycle: ser_en=1; ser_d = current head bit (bit 0 if LSB_FIRST, else bit WIDTH-1).
  - Shift register moves one position toward the head; bit counter increments.
  - ser_last=1 when bit counter = WIDTH-1.
  - busy=1 throughout.
- Latency: a handshake in cycle N produces the first bit in cycle N+1 and the last bit in cycle N+WIDTH.
- Back-to-back transfers:
  - in_ready=1 during the ser_last cycle.
  - If in_valid is also high in that cycle, the new word loads and its first bit appears in the next cycle. ser_en stays high with no gap, and state stays SHIFT.
  - Otherwise return to IDLE; the next cycle has ser_en=0, ser_d=0, busy=0.
- word_count:
  - Increments by 1 in the cycle after each ser_last cycle, i.e. on the same edge that retires the last bit.
  - Wraps from 2^CNT_W-1 to 0 with no flag.
- in_data is sampled only on the handshake edge; later changes have no effect on the word in flight.
- in_valid while in_ready=0 is ignored. The upstream must hold valid until it sees ready.
- Reset asserted mid-word: the word is aborted immediately (asynchronous), the partial bits are discarded, and word_count is not incremented.
- ser_d and ser_last are 0 whenever ser_en=0.

Test Plan:
- Reset/idle: release rst, in_valid=0 for 10 cycles → in_ready=1, ser_en=0, busy=0, word_count=0 throughout.
- Single word, WIDTH=8, LSB_FIRST=1, in_data=8'hA5:
  - ser_d sequence = 1,0,1,0,0,1,0,1 on 8 consecutive ser_en cycles, starting 1 cycle after the handshake.
  - ser_last high only on the 8th bit.
  - word_count=1 afterwards.
- Back-to-back, 8'h01 then 8'h80 with in_valid held high:
  - 16 contiguous ser_en cycles.
  - Bits = 1,0×7 then 0×7,1.
  - Exactly one handshake per ser_last; word_count=2.
- MSB-first, LSB_FIRST=0, in_data=8'hC3: ser_d = 1,1,0,0,0,0,1,1.
- Reset mid-word: assert rst after the 3rd bit of 8'hFF → ser_en=0 immediately (same cycle, asynchronous), word_count stays 0, in_ready=1 after release.
- Counter wrap, CNT_W=2: send 5 words → word_count = 1,2,3,0,1.
- Loopback: feed ser_en/ser_d into an 8-deep chain of enabled capture flops → after ser_last the chain holds the transmitted word.
